// File: rtl/pq_sevenseg_scan_pkg.sv
// Shared display types and the hex-to-segment glyph table.
// Pure declarations; no latency and no flow control.
// Not applicable: the package holds no logic that could stall.
package pq_sevenseg_scan_pkg;

   localparam int NUM_DIGITS = 4;

   typedef logic [6:0] seg_t;     // {g,f,e,d,c,b,a}, active-high
   typedef logic [3:0] nibble_t;

   // b and d are lowercase so they stay distinguishable from 8 and 0.
   function automatic seg_t hex_to_seg(input nibble_t nib);
      seg_t glyph;
      case (nib)
         4'h0: glyph = 7'h3F;
         4'h1: glyph = 7'h06;
         4'h2: glyph = 7'h5B;
         4'h3: glyph = 7'h4F;
         4'h4: glyph = 7'h66;
         4'h5: glyph = 7'h6D;
         4'h6: glyph = 7'h7D;
         4'h7: glyph = 7'h07;
         4'h8: glyph = 7'h7F;
         4'h9: glyph = 7'h6F;
         4'hA: glyph = 7'h77;
         4'hB: glyph = 7'h7C;
         4'hC: glyph = 7'h39;
         4'hD: glyph = 7'h5E;
         4'hE: glyph = 7'h79;
         4'hF: glyph = 7'h71;
         default: glyph = 7'h00;
      endcase
      return glyph;
   endfunction

endpackage

// File: rtl/pq_sevenseg_scan_hex7seg.sv
// Combinational nibble to active-high seven-segment glyph decoder.
// Zero latency.
// No backpressure; output follows input.
module pq_sevenseg_scan_hex7seg
   import pq_sevenseg_scan_pkg::*;
(
   input  nibble_t nib,
   output seg_t    seg
);

   assign seg = hex_to_seg(nib);

endmodule

// File: rtl/pq_sevenseg_scan.sv
// Latches a key/value byte pair and scans it as four hex digits onto a muxed display.
// One cycle from capture or digit advance to the pins.
// No backpressure: toDisplay is sampled every cycle and the last value wins.
module pq_sevenseg_scan
   import pq_sevenseg_scan_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter bit ACTIVE_LOW  = 1'b1
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            data1,
   input  logic [7:0]            data2,
   input  logic                  toDisplay,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic                  shown
);

   localparam int              CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic            POL      = ACTIVE_LOW;

   logic [CNT_W-1:0]      cnt;
   logic [1:0]            idx;
   logic [15:0]           cap;
   nibble_t               cur_nib;
   seg_t                  cur_seg;
   logic [NUM_DIGITS-1:0] an_act;

   always_comb begin
      cur_nib = cap[3:0];
      case (idx)
         2'd0: cur_nib = cap[3:0];
         2'd1: cur_nib = cap[7:4];
         2'd2: cur_nib = cap[11:8];
         2'd3: cur_nib = cap[15:12];
         default: cur_nib = cap[3:0];
      endcase
      an_act = 4'b0001 << idx;
   end

   pq_sevenseg_scan_hex7seg u_hex7seg (
      .nib (cur_nib),
      .seg (cur_seg)
   );

   // Pins are built from the pre-edge idx/cap/shown, so every change lands one edge later.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         idx   <= '0;
         cap   <= '0;
         shown <= 1'b0;
         an    <= {NUM_DIGITS{POL}};
         seg   <= {7{POL}};
         dp    <= POL;
      end else begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
         end else begin
            cnt <= cnt + 1'b1;
         end

         if (toDisplay) begin
            cap   <= {data1, data2};
            shown <= 1'b1;
         end

         if (shown) begin
            an  <= an_act ^ {NUM_DIGITS{POL}};
            seg <= cur_seg ^ {7{POL}};
            dp  <= (idx == 2'd2) ^ POL;
         end else begin
            an  <= {NUM_DIGITS{POL}};
            seg <= {7{POL}};
            dp  <= POL;
         end
      end
   end

endmodule

// File: doc/pq_sevenseg_scan.md
Name: pq_sevenseg_scan

Overview:
- Downstream display stage for the priority-queue demo top level.
- Consumes the 8-bit `data1` and `data2` bytes and the `toDisplay` strobe produced by the auto-driver client.
- Latches the displayed key/value pair and time-multiplexes it onto a 4-digit common-anode seven-segment display as four hex digits.
- Blanks the display until the first capture.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit stays active (1 kHz per digit at 100 MHz); legal range 2..2^24.
- ACTIVE_LOW, 1, 1 = `an`/`seg`/`dp` driven active-low (board default); 0 = active-high.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- data1  input  8  key byte from auto client; sampled only when `toDisplay`=1.
- data2  input  8  value byte from auto client; sampled only when `toDisplay`=1.
- toDisplay  input  1  capture strobe; level-sampled each cycle.
- an  output  4  digit enables; one-hot active digit; all inactive when blank.
- seg  output  7  segments {g,f,e,d,c,b,a}.
- dp  output  1  decimal point.
- shown  output  1  high once any value has been captured since reset.

Behaviour:
- Reset (`rst`=1 at an edge):
  - cnt=0, idx=0, cap={data1,data2}=16'h0000, shown=0.
  - an = all inactive, seg = all off, dp = off.
  - Reset mid-scan blanks the display at that same edge.
- Capture:
  - On an edge with `toDisplay`=1 and `rst`=0: cap <= {data1,data2}, shown <= 1.
  - `toDisplay` held high recaptures every cycle; the last sampled value wins.
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1.
  - At cnt==REFRESH_DIV-1: cnt <= 0, idx <= idx+1 (2-bit wrap, 3→0).
  - Width is $clog2(REFRESH_DIV).
- Digit map:
  - idx 3 = cap[15:12] (data1 hi)
  - idx 2 = cap[11:8] (data1 lo)
  - idx 1 = cap[7:4] (data2 hi)
  - idx 0 = cap[3:0] (data2 lo)
  - an bit idx is active.
- Decimal point: lit only on idx 2, separating key from value.
- Output timing:
  - an/seg/dp are registered from the current (pre-edge) idx and cap; one cycle of latency from the idx/cap change to the pins.
  - A capture at edge N is visible on pins at edge N+1.
- Simultaneous capture and digit advance at the same edge: idx and cap both update; the next edge shows the new cap on the new digit. No stale/new mix within one digit slot beyond that single cycle.
- Blank mode (shown=0): an all inactive, seg off, dp off; prescaler and idx still run.
- Hex decode: standard 0-F glyphs, lowercase for b and d, uppercase for A, C, E, F:

      0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
      8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71

  - Values are active-high {g..a}.
  - ACTIVE_LOW inverts `seg`, `an` and `dp` at the output register.
- No other state. Inputs are synchronous to clk.

Decomposition:
- pq_pkg additions:
  - `localparam int NUM_DIGITS = 4`
  - `typedef logic [6:0] seg_t`
  - `typedef logic [3:0] nibble_t`
  - function `hex_to_seg(nibble_t) -> seg_t` holding the table above, shared with future display blocks.
- Sub-module `hex7seg`: purely combinational nibble→seg_t wrapper around `hex_to_seg`, instantiated once on the muxed nibble.
- Top-level integration: the top module wires data1/data2/toDisplay from the auto client into this block and routes `an`/`seg`/`dp` to pins.

Test Plan (REFRESH_DIV=4, ACTIVE_LOW=1):
- **Reset, no capture.** Assert rst 2 cycles, then run 40 cycles with toDisplay=0. Required: an=4'b1111, seg=7'h7F, dp=1, shown=0 throughout.
- **Single capture.** Pulse toDisplay 1 cycle with data1=8'hA5, data2=8'h3C. Required: shown=1 next edge. Over 16 cycles the pins cycle:
  - an=1110 → seg=~39 (C)
  - an=1101 → ~4F (3)
  - an=1011 → ~6D (5), dp=0
  - an=0111 → ~77 (A)
  - Each digit is held exactly 4 cycles.
- **Capture at terminal count.** Raise toDisplay with 8'hFF/8'h00 exactly when cnt=3. Required: the next digit slot already shows the new data (~71 for F, or ~3F for 0); no old glyph appears after that cycle.
- **Continuous toDisplay.** Hold toDisplay high while ramping data2 0..15 per cycle. Required: each slot shows the data2 value of the previous cycle; no X on the outputs.
- **Reset mid-scan.** Capture 8'h12/8'h34, wait 7 cycles, assert rst 1 cycle. Required: next edge all blank, shown=0, cnt/idx restart with an=1110 first after a new capture.
- **All glyphs.** Sweep data2[3:0]=0..F, observing idx 0. Required: seg matches the decode table for every nibble.
